mouse_cell_tracker: RTL and testbench
=====================================

Name: mouse_cell_tracker

Overview:
- Upstream stage of the drawing circuit: sits between the PS/2 byte-level controller and the drawing datapath.
- Enables mouse data reporting, then assembles 3-byte PS/2 movement packets into button levels.
- Accumulates signed deltas into a clamped, grid-cell cursor position (X/Y cell indices plus left/right button levels) consumed by the drawing circuit.

Parameters:
- SCREEN_WIDTH, 320, display width in pixels.
- SCREEN_HEIGHT, 240, display height in pixels.
- CELL_DIMENSION, 5, pixels per drawing cell edge.
- COUNTS_PER_CELL, 4, mouse counts per cell step; must be a power of two.
- Derived (localparams): GRID_W=SCREEN_WIDTH/CELL_DIMENSION (64), GRID_H=SCREEN_HEIGHT/CELL_DIMENSION (48), UPPER_BITS=$clog2(max(GRID_W,GRID_H)) (6), SH=$clog2(COUNTS_PER_CELL).

Ports:
- iClk  in  1  system clock.
- iResetn  in  1  asynchronous active-low reset.
- iStartTransmission  in  1  one-cycle request to (re)initialise the mouse.
- iEnableMouse  in  1  level; 1 = apply packets to outputs.
- iReceivedData  in  8  byte from PS/2 controller.
- iReceivedDataEn  in  1  one-cycle strobe, iReceivedData valid.
- iCommandWasSent  in  1  one-cycle strobe, controller finished sending oCommand.
- iErrorCommunication  in  1  one-cycle strobe, controller send timeout/error.
- oCommand  out  8  command byte to controller.
- oSendCommand  out  1  one-cycle send request.
- oX_cell  out  UPPER_BITS  cursor cell column, 0..GRID_W-1.
- oY_cell  out  UPPER_BITS  cursor cell row, 0..GRID_H-1 (0 = top).
- oBtnL  out  1  left button level.
- oBtnR  out  1  right button level.
- oPacketValid  out  1  one-cycle pulse when a packet is applied.
- oMouseReady  out  1  high once the mouse has ACKed enable.

Behaviour:
- Reset (async, iResetn=0):
  - state=S_IDLE; oCommand=8'hF4; oSendCommand=0; oBtnL=oBtnR=0; oPacketValid=0; oMouseReady=0.
  - Count positions posX=(GRID_W/2)<<SH, posY=(GRID_H/2)<<SH, so oX_cell=32, oY_cell=24.
- All outputs are registered; oX_cell=posX>>SH and oY_cell=posY>>SH.
- FSM states and transitions:
  - S_IDLE: on iStartTransmission go to S_SEND.
  - S_SEND: oSendCommand=1 for exactly one cycle with oCommand=F4; then go to S_WAIT_SENT.
  - S_WAIT_SENT:
    - iCommandWasSent -> S_WAIT_ACK.
    - iErrorCommunication -> S_SEND (retry).
  - S_WAIT_ACK, on iReceivedDataEn:
    - byte FA -> oMouseReady=1, go to S_BYTE0.
    - any other byte -> S_SEND (retry).
    - iErrorCommunication -> S_SEND.
  - S_BYTE0, on strobe:
    - bit3=1: latch byte as status, go to S_BYTE1.
    - bit3=0: discard byte, stay (resync).
  - S_BYTE1: on strobe latch dx_lo, go to S_BYTE2.
  - S_BYTE2: on strobe apply the packet, go to S_BYTE0.
- iStartTransmission in any non-IDLE state:
  - Go to S_SEND and clear oMouseReady.
  - Any partial packet is dropped.
  - Position and buttons are held.
- Packet application (cycle after the byte-2 strobe):
  - dx={status[4],byte1} and dy={status[5],byte2}, both 9-bit two's complement.
  - newX=clamp(posX+dx, 0, (GRID_W<<SH)-1).
  - newY=clamp(posY-dy, 0, (GRID_H<<SH)-1), because PS/2 Y is up-positive.
  - Compute in signed width ≥ count width+2; no wrap-around permitted.
  - status[6] (X overflow) set -> X delta ignored; status[7] (Y overflow) set -> Y delta ignored.
  - Buttons always taken from status[0] (left) and status[1] (right).
  - If iEnableMouse=1:
    - Update position and buttons.
    - Pulse oPacketValid together with the new oX_cell/oY_cell (latency 1 cycle after the byte-2 strobe).
  - If iEnableMouse=0:
    - Packet is parsed (sync kept), position is held.
    - oBtnL=oBtnR forced 0; no oPacketValid.
- iReceivedDataEn ignored in S_IDLE, S_SEND, S_WAIT_SENT.
- Simultaneous iStartTransmission and byte-2 strobe: restart wins and the packet is dropped.

Test Plan:
- Reset, pulse iStartTransmission -> exactly one oSendCommand pulse with oCommand=F4; after iCommandWasSent and byte FA -> oMouseReady=1; oX_cell=32, oY_cell=24.
- Ready; send packet 09,08,08 -> one cycle after the third strobe: oX_cell=34, oY_cell=22, oBtnL=1, oBtnR=0, oPacketValid pulse.
- Packet 18,00,00 repeated (dx=-256 each) -> oX_cell clamps to 0 and stays 0; then packet 08,FF,00 repeated -> oX_cell saturates at 63, never wraps.
- Stray byte 00 in S_BYTE0, then 0A,04,00 -> 00 discarded; oX_cell +1, oBtnR=1.
- iErrorCommunication in S_WAIT_SENT, then byte FE instead of FA -> two further F4 retries; oMouseReady stays 0 until FA is received.
- iEnableMouse=0, send 09,40,00 -> no oPacketValid, oX_cell unchanged, oBtnL=0; assert iResetn=0 mid-packet -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/mouse_cell_tracker.sv
// PS/2 mouse front end: enables data reporting, parses 3-byte movement packets
// and tracks a clamped grid-cell cursor position plus button levels.
module mouse_cell_tracker #(
   parameter int SCREEN_WIDTH    = 320,
   parameter int SCREEN_HEIGHT   = 240,
   parameter int CELL_DIMENSION  = 5,
   parameter int COUNTS_PER_CELL = 4,
   localparam int GRID_W     = SCREEN_WIDTH / CELL_DIMENSION,
   localparam int GRID_H     = SCREEN_HEIGHT / CELL_DIMENSION,
   localparam int UPPER_BITS = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H)
) (
   input  logic                  iClk,
   input  logic                  iResetn,
   input  logic                  iStartTransmission,
   input  logic                  iEnableMouse,
   input  logic [7:0]            iReceivedData,
   input  logic                  iReceivedDataEn,
   input  logic                  iCommandWasSent,
   input  logic                  iErrorCommunication,
   output logic [7:0]            oCommand,
   output logic                  oSendCommand,
   output logic [UPPER_BITS-1:0] oX_cell,
   output logic [UPPER_BITS-1:0] oY_cell,
   output logic                  oBtnL,
   output logic                  oBtnR,
   output logic                  oPacketValid,
   output logic                  oMouseReady
);

   localparam int SH = $clog2(COUNTS_PER_CELL);
   localparam int CW = UPPER_BITS + SH;
   localparam int AW = ((CW > 9) ? CW : 9) + 2;

   localparam logic signed [AW-1:0] X_MAX  = AW'((GRID_W << SH) - 1);
   localparam logic signed [AW-1:0] Y_MAX  = AW'((GRID_H << SH) - 1);
   localparam logic [CW-1:0]        X_INIT = CW'((GRID_W / 2) << SH);
   localparam logic [CW-1:0]        Y_INIT = CW'((GRID_H / 2) << SH);
   localparam logic [7:0]           CMD_ENABLE = 8'hF4;
   localparam logic [7:0]           BYTE_ACK   = 8'hFA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_SENT,
      S_WAIT_ACK,
      S_BYTE0,
      S_BYTE1,
      S_BYTE2
   } state_t;

   state_t state, state_n;

   logic [CW-1:0] posx, posy;
   logic [1:0]    st_btn;
   logic          st_xs, st_ys, st_xo, st_yo;
   logic [7:0]    dx_lo;
   logic          apply, ack, latch_status, latch_dx;

   logic signed [AW-1:0] dx_s, dy_s, sum_x, sum_y;
   logic [CW-1:0]        newx, newy;

   function automatic logic [CW-1:0] clamp_count(input logic signed [AW-1:0] v,
                                                 input logic signed [AW-1:0] vmax);
      if (v[AW-1])
         clamp_count = '0;
      else if (v > vmax)
         clamp_count = vmax[CW-1:0];
      else
         clamp_count = v[CW-1:0];
   endfunction

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n      = state;
      apply        = 1'b0;
      ack          = 1'b0;
      latch_status = 1'b0;
      latch_dx     = 1'b0;
      if (iStartTransmission) begin
         state_n = S_SEND;
      end else begin
         case (state)
            S_IDLE:      state_n = S_IDLE;
            S_SEND:      state_n = S_WAIT_SENT;
            S_WAIT_SENT: begin
               if (iErrorCommunication)
                  state_n = S_SEND;
               else if (iCommandWasSent)
                  state_n = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (iErrorCommunication) begin
                  state_n = S_SEND;
               end else if (iReceivedDataEn) begin
                  if (iReceivedData == BYTE_ACK) begin
                     ack     = 1'b1;
                     state_n = S_BYTE0;
                  end else begin
                     state_n = S_SEND;
                  end
               end
            end
            // bytes without the always-one bit 3 cannot start a packet
            S_BYTE0: begin
               if (iReceivedDataEn && iReceivedData[3]) begin
                  latch_status = 1'b1;
                  state_n      = S_BYTE1;
               end
            end
            S_BYTE1: begin
               if (iReceivedDataEn) begin
                  latch_dx = 1'b1;
                  state_n  = S_BYTE2;
               end
            end
            S_BYTE2: begin
               if (iReceivedDataEn) begin
                  apply   = 1'b1;
                  state_n = S_BYTE0;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // signed sums are wide enough that the full dx/dy range never wraps
   always_comb begin
      dx_s  = st_xo ? '0 : {{(AW-8){st_xs}}, dx_lo};
      dy_s  = st_yo ? '0 : {{(AW-8){st_ys}}, iReceivedData};
      sum_x = $signed({{(AW-CW){1'b0}}, posx}) + dx_s;
      sum_y = $signed({{(AW-CW){1'b0}}, posy}) - dy_s;
      newx  = clamp_count(sum_x, X_MAX);
      newy  = clamp_count(sum_y, Y_MAX);
   end

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         oCommand     <= CMD_ENABLE;
         oSendCommand <= 1'b0;
         oMouseReady  <= 1'b0;
         oPacketValid <= 1'b0;
         oBtnL        <= 1'b0;
         oBtnR        <= 1'b0;
         posx         <= X_INIT;
         posy         <= Y_INIT;
         st_btn       <= 2'b00;
         st_xs        <= 1'b0;
         st_ys        <= 1'b0;
         st_xo        <= 1'b0;
         st_yo        <= 1'b0;
         dx_lo        <= 8'h00;
      end else begin
         oSendCommand <= (state_n == S_SEND);
         if (state_n == S_SEND)
            oCommand <= CMD_ENABLE;
         if (iStartTransmission)
            oMouseReady <= 1'b0;
         else if (ack)
            oMouseReady <= 1'b1;
         oPacketValid <= apply && iEnableMouse;
         if (latch_status) begin
            st_btn <= iReceivedData[1:0];
            st_xs  <= iReceivedData[4];
            st_ys  <= iReceivedData[5];
            st_xo  <= iReceivedData[6];
            st_yo  <= iReceivedData[7];
         end
         if (latch_dx)
            dx_lo <= iReceivedData;
         if (apply) begin
            if (iEnableMouse) begin
               posx  <= newx;
               posy  <= newy;
               oBtnL <= st_btn[0];
               oBtnR <= st_btn[1];
            end else begin
               oBtnL <= 1'b0;
               oBtnR <= 1'b0;
            end
         end
      end
   end

   assign oX_cell = posx[CW-1:SH];
   assign oY_cell = posy[CW-1:SH];

endmodule

// File: tb/tb_mouse_cell_tracker.sv
// Directed bench for mouse_cell_tracker: handshake, packet parsing, clamping,
// resync, retries, disabled mode and asynchronous reset.
module tb_mouse_cell_tracker;

   logic       iClk = 1'b0;
   logic       iResetn = 1'b0;
   logic       iStartTransmission = 1'b0;
   logic       iEnableMouse = 1'b1;
   logic [7:0] iReceivedData = 8'h00;
   logic       iReceivedDataEn = 1'b0;
   logic       iCommandWasSent = 1'b0;
   logic       iErrorCommunication = 1'b0;
   logic [7:0] oCommand;
   logic       oSendCommand;
   logic [5:0] oX_cell;
   logic [5:0] oY_cell;
   logic       oBtnL, oBtnR, oPacketValid, oMouseReady;

   int checks = 0;
   int errors = 0;
   int send_cnt = 0;
   int base;

   mouse_cell_tracker dut (
      .iClk(iClk),
      .iResetn(iResetn),
      .iStartTransmission(iStartTransmission),
      .iEnableMouse(iEnableMouse),
      .iReceivedData(iReceivedData),
      .iReceivedDataEn(iReceivedDataEn),
      .iCommandWasSent(iCommandWasSent),
      .iErrorCommunication(iErrorCommunication),
      .oCommand(oCommand),
      .oSendCommand(oSendCommand),
      .oX_cell(oX_cell),
      .oY_cell(oY_cell),
      .oBtnL(oBtnL),
      .oBtnR(oBtnR),
      .oPacketValid(oPacketValid),
      .oMouseReady(oMouseReady)
   );

   always #5 iClk = ~iClk;

   always @(posedge iClk)
      if (iResetn && oSendCommand)
         send_cnt <= send_cnt + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] b);
      iReceivedData   = b;
      iReceivedDataEn = 1'b1;
      tick();
      iReceivedDataEn = 1'b0;
   endtask

   task automatic put_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      put_byte(b0);
      put_byte(b1);
      put_byte(b2);
   endtask

   task automatic pulse_start();
      iStartTransmission = 1'b1;
      tick();
      iStartTransmission = 1'b0;
   endtask

   task automatic pulse_sent();
      iCommandWasSent = 1'b1;
      tick();
      iCommandWasSent = 1'b0;
   endtask

   task automatic pulse_err();
      iErrorCommunication = 1'b1;
      tick();
      iErrorCommunication = 1'b0;
   endtask

   initial begin
      // reset values
      tick();
      chk("rst_cmd", oCommand, 8'hF4);
      chk("rst_send", oSendCommand, 0);
      chk("rst_ready", oMouseReady, 0);
      chk("rst_x", oX_cell, 32);
      chk("rst_y", oY_cell, 24);
      chk("rst_btnl", oBtnL, 0);
      chk("rst_btnr", oBtnR, 0);
      chk("rst_pv", oPacketValid, 0);
      iResetn = 1'b1;
      tick();

      // enable handshake
      base = send_cnt;
      pulse_start();
      chk("init_send_hi", oSendCommand, 1);
      chk("init_cmd", oCommand, 8'hF4);
      tick();
      chk("init_send_lo", oSendCommand, 0);
      pulse_sent();
      chk("init_not_ready", oMouseReady, 0);
      put_byte(8'hFA);
      chk("init_ready", oMouseReady, 1);
      chk("init_send_cnt", send_cnt - base, 1);
      chk("init_x", oX_cell, 32);
      chk("init_y", oY_cell, 24);

      // basic packet: dx=+8, dy=+8 counts
      put_pkt(8'h09, 8'h08, 8'h08);
      chk("p1_pv", oPacketValid, 1);
      chk("p1_x", oX_cell, 34);
      chk("p1_y", oY_cell, 22);
      chk("p1_btnl", oBtnL, 1);
      chk("p1_btnr", oBtnR, 0);
      tick();
      chk("p1_pv_lo", oPacketValid, 0);

      // dx=-256 clamps at the left edge
      put_pkt(8'h18, 8'h00, 8'h00);
      chk("clamp0_a", oX_cell, 0);
      put_pkt(8'h18, 8'h00, 8'h00);
      chk("clamp0_b", oX_cell, 0);
      chk("clamp0_y", oY_cell, 22);

      // stray byte without bit 3 is discarded
      put_byte(8'h00);
      chk("stray_pv", oPacketValid, 0);
      put_pkt(8'h0A, 8'h04, 8'h00);
      chk("resync_x", oX_cell, 1);
      chk("resync_btnr", oBtnR, 1);
      chk("resync_btnl", oBtnL, 0);

      // X overflow flag suppresses the X delta
      put_pkt(8'h48, 8'h10, 8'h00);
      chk("xovf_x", oX_cell, 1);
      chk("xovf_pv", oPacketValid, 1);

      // dx=+255 saturates at the right edge
      put_pkt(8'h08, 8'hFF, 8'h00);
      chk("sat_a", oX_cell, 63);
      put_pkt(8'h08, 8'hFF, 8'h00);
      chk("sat_b", oX_cell, 63);

      // dy=+127 moves the cursor up past row 0
      put_pkt(8'h08, 8'h00, 8'h7F);
      chk("ytop", oY_cell, 0);

      // restart with one send error and one bad ack
      base = send_cnt;
      pulse_start();
      chk("retry_ready_clr", oMouseReady, 0);
      tick();
      pulse_err();
      tick();
      pulse_sent();
      put_byte(8'hFE);
      chk("retry_nak_ready", oMouseReady, 0);
      tick();
      pulse_sent();
      put_byte(8'hFA);
      chk("retry_ready", oMouseReady, 1);
      chk("retry_send_cnt", send_cnt - base, 3);
      chk("retry_x_held", oX_cell, 63);

      put_pkt(8'h09, 8'h00, 8'h00);
      chk("en_btnl", oBtnL, 1);

      // disabled: packet parsed but not applied
      iEnableMouse = 1'b0;
      put_pkt(8'h09, 8'h40, 8'h00);
      chk("dis_pv", oPacketValid, 0);
      chk("dis_x", oX_cell, 63);
      chk("dis_btnl", oBtnL, 0);
      iEnableMouse = 1'b1;
      put_pkt(8'h08, 8'h00, 8'h00);
      chk("dis_sync_pv", oPacketValid, 1);

      // asynchronous reset in the middle of a packet
      put_byte(8'h09);
      put_byte(8'h40);
      #2;
      iResetn = 1'b0;
      #1;
      chk("arst_x", oX_cell, 32);
      chk("arst_y", oY_cell, 24);
      chk("arst_ready", oMouseReady, 0);
      chk("arst_btnl", oBtnL, 0);
      chk("arst_cmd", oCommand, 8'hF4);
      chk("arst_send", oSendCommand, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
